snake_body_streamer: RTL



---
 rtl/snake_body_streamer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/snake_body_streamer.sv
// Snake segment store with move/grow/collision logic and a per-frame
// serial segment stream toward the renderer (one segment per clock).
module snake_body_streamer #(
  parameter int LENGTH_MAX = 32,
  parameter int LEN_BIT    = 6,
  parameter int GRID_X_MAX = 123,
  parameter int GRID_Y_MAX = 80,
  parameter int INIT_X     = 62,
  parameter int INIT_Y     = 40
) (
  input  logic               clock_25,
  input  logic               reset,
  input  logic               move_tick,
  input  logic               grow,
  input  logic [1:0]         direction,
  input  logic               frame_start,
  output logic [6:0]         snake_head_x,
  output logic [6:0]         snake_head_y,
  output logic [6:0]         snake_body_x,
  output logic [6:0]         snake_body_y,
  output logic               en_snake_body,
  output logic [LEN_BIT-1:0] snake_length,
  output logic               collision,
  output logic               busy
);

  localparam int IDX_W = $clog2(LENGTH_MAX);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {IDLE, MOVE, STREAM} state_t;

  state_t             state;
  logic [6:0]         seg_x [LENGTH_MAX];
  logic [6:0]         seg_y [LENGTH_MAX];
  logic [1:0]         dir_q;
  logic               move_pend;
  logic               frame_pend;
  logic               grow_q;
  logic [LEN_BIT-1:0] stream_len;
  logic [LEN_BIT-1:0] stream_idx;

  logic [1:0]         move_dir;
  logic [6:0]         next_x;
  logic [6:0]         next_y;
  logic               wall_hit;
  logic               self_hit;
  logic               grow_eff;
  logic [LEN_BIT-1:0] len_m1;

  // UP<->DOWN and LEFT<->RIGHT differ only in the low bit.
  function automatic logic [1:0] reverse_dir(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

  assign busy = (state != IDLE);

  // Next head position, wall test and self-overlap test for the pending move.
  always_comb begin
    move_dir = (direction == reverse_dir(dir_q)) ? dir_q : direction;
    next_x   = seg_x[0];
    next_y   = seg_y[0];
    wall_hit = 1'b0;
    case (move_dir)
      DIR_UP:    if (seg_y[0] == 7'd0) wall_hit = 1'b1; else next_y = seg_y[0] - 7'd1;
      DIR_DOWN:  if (seg_y[0] == 7'(GRID_Y_MAX)) wall_hit = 1'b1; else next_y = seg_y[0] + 7'd1;
      DIR_LEFT:  if (seg_x[0] == 7'd0) wall_hit = 1'b1; else next_x = seg_x[0] - 7'd1;
      default:   if (seg_x[0] == 7'(GRID_X_MAX)) wall_hit = 1'b1; else next_x = seg_x[0] + 7'd1;
    endcase
    grow_eff = grow_q && (snake_length < LEN_BIT'(LENGTH_MAX));
    len_m1   = snake_length - LEN_BIT'(1);
    self_hit = 1'b0;
    // The tail vacates its cell on a plain move, so it only blocks when it stays.
    for (int i = 0; i < LENGTH_MAX; i++) begin
      if ((LEN_BIT'(i) < len_m1) || (grow_eff && (LEN_BIT'(i) == len_m1))) begin
        if ((seg_x[i] == next_x) && (seg_y[i] == next_y)) self_hit = 1'b1;
      end
    end
  end

  // Control FSM, segment store update and registered stream outputs.
  always_ff @(posedge clock_25) begin
    if (!reset) begin
      state         <= IDLE;
      dir_q         <= DIR_RIGHT;
      move_pend     <= 1'b0;
      frame_pend    <= 1'b0;
      grow_q        <= 1'b0;
      stream_len    <= '0;
      stream_idx    <= '0;
      snake_length  <= LEN_BIT'(3);
      snake_head_x  <= 7'(INIT_X);
      snake_head_y  <= 7'(INIT_Y);
      snake_body_x  <= 7'd0;
      snake_body_y  <= 7'd0;
      en_snake_body <= 1'b0;
      collision     <= 1'b0;
      for (int i = 0; i < LENGTH_MAX; i++) begin
        seg_x[i] <= (i < 3) ? 7'(INIT_X - i) : 7'd0;
        seg_y[i] <= (i < 3) ? 7'(INIT_Y) : 7'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          // After game over, any stored move request is simply dropped.
          if (collision) move_pend <= 1'b0;
          if ((move_tick || move_pend) && !collision) begin
            state     <= MOVE;
            move_pend <= 1'b0;
            grow_q    <= (move_pend & grow_q) | (move_tick & grow);
            if (frame_start) frame_pend <= 1'b1;
          end else if (frame_start || frame_pend) begin
            state         <= STREAM;
            frame_pend    <= 1'b0;
            stream_len    <= snake_length;
            stream_idx    <= LEN_BIT'(1);
            en_snake_body <= 1'b1;
            snake_body_x  <= seg_x[0];
            snake_body_y  <= seg_y[0];
          end else if (move_tick && !move_pend) begin
            grow_q <= 1'b0;
          end
        end
        MOVE: begin
          state <= IDLE;
          dir_q <= move_dir;
          if (move_tick)   move_pend  <= 1'b1;
          if (frame_start) frame_pend <= 1'b1;
          if (wall_hit || self_hit) begin
            collision <= 1'b1;
          end else begin
            for (int i = LENGTH_MAX - 1; i > 0; i--) begin
              seg_x[i] <= seg_x[i-1];
              seg_y[i] <= seg_y[i-1];
            end
            seg_x[0]     <= next_x;
            seg_y[0]     <= next_y;
            snake_head_x <= next_x;
            snake_head_y <= next_y;
            if (grow_eff) snake_length <= snake_length + LEN_BIT'(1);
          end
        end
        STREAM: begin
          if (move_tick)   move_pend  <= 1'b1;
          if (frame_start) frame_pend <= 1'b1;
          if (stream_idx < stream_len) begin
            snake_body_x <= seg_x[stream_idx[IDX_W-1:0]];
            snake_body_y <= seg_y[stream_idx[IDX_W-1:0]];
            stream_idx   <= stream_idx + LEN_BIT'(1);
          end else begin
            en_snake_body <= 1'b0;
            snake_body_x  <= 7'd0;
            snake_body_y  <= 7'd0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
